// File: rtl/cmd_responder_sclk_if.sv
// ---------------------------------------------------------------------------
// cmd_responder_sclk_if
// Command/response bundle between the PCLK-side initiator and the SCLK-side
// responder (cmd_responder_sclk).
//   req_pclk        initiator request level (asynchronous to SCLK)
//   CMD_REG_pclk    command code, quasi-static while req is high
//   ADDR_REG_pclk   word address, quasi-static
//   WDATA_REG_pclk  write data, quasi-static
//   ABORT_REG_pclk  abort level (asynchronous)
//   ack_sclk        4-phase acknowledge; RDATA/RESP valid while high
//   RDATA_sclk      read data
//   RESP_sclk       1 = error or aborted
//   busy_sclk       responder is executing a command
// ---------------------------------------------------------------------------
interface cmd_responder_sclk_if;
  logic       req_pclk;
  logic [2:0] CMD_REG_pclk;
  logic [9:0] ADDR_REG_pclk;
  logic [9:0] WDATA_REG_pclk;
  logic       ABORT_REG_pclk;
  logic       ack_sclk;
  logic [9:0] RDATA_sclk;
  logic       RESP_sclk;
  logic       busy_sclk;

  modport master (
    output req_pclk, CMD_REG_pclk, ADDR_REG_pclk, WDATA_REG_pclk, ABORT_REG_pclk,
    input  ack_sclk, RDATA_sclk, RESP_sclk, busy_sclk
  );

  modport slave (
    input  req_pclk, CMD_REG_pclk, ADDR_REG_pclk, WDATA_REG_pclk, ABORT_REG_pclk,
    output ack_sclk, RDATA_sclk, RESP_sclk, busy_sclk
  );
endinterface

// File: rtl/cmd_responder_sclk.sv
// ---------------------------------------------------------------------------
// cmd_responder_sclk
// SCLK-domain responder of the GFB command handshake. Synchronizes req_pclk,
// captures the command bundle on the request rising edge, executes it against
// a local word array and answers with a 4-phase ack_sclk carrying RDATA/RESP.
//   SCLK         sole clock
//   RESETn_sclk  asynchronous active-low reset
//   bus          cmd_responder_sclk_if.slave (request bundle in, response out)
// Optional feature macro: GFB_RSP_ABORT_EN -- when defined, ABORT_REG_pclk is
// synchronized and terminates ROW_WRITE / MASS_ERASE early with RESP=1.
// ---------------------------------------------------------------------------
module cmd_responder_sclk #(
  parameter int DEPTH       = 64,  // implemented words
  parameter int ROW_SIZE    = 8,   // words per row, power of 2 dividing DEPTH
  parameter int BUSY_CYCLES = 2    // extra execute cycles for single-word ops
) (
  input logic                SCLK,
  input logic                RESETn_sclk,
  cmd_responder_sclk_if.slave bus
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (DEPTH > BUSY_CYCLES) ? DEPTH : BUSY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_READ       = 3'd1,
    CMD_WRITE      = 3'd2,
    CMD_ROW_WRITE  = 3'd3,
    CMD_ERASE      = 3'd4,
    CMD_MASS_ERASE = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e          state, next_state;
  logic            req_s1, req_s2, req_s3;
  logic [1:0]      primed;
  logic            armed;
  logic            start;
  logic            abort_s2;
  logic [2:0]      cmd_q;
  logic [9:0]      addr_q, wdata_q;
  logic [CW-1:0]   cnt;
  logic [9:0]      mem [DEPTH];

  logic            addr_err, finish, fin_err, load_rdata, clr_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [9:0]      mem_wdata;

  // Request synchronizer and edge detector. The edge detector only arms once
  // a genuine low has travelled through the synchronizer after reset, so a
  // request level that was already high across reset never starts an op.
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      req_s3 <= 1'b0;
      primed <= 2'b00;
      armed  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage take the previous
      // stage's old value, which is what makes this a shift chain.
      req_s1 <= bus.req_pclk;
      req_s2 <= req_s1;
      req_s3 <= req_s2;
      primed <= {primed[0], 1'b1};
      armed  <= armed | (primed[1] & ~req_s2);
    end
  end

  assign start = req_s2 & ~req_s3 & armed;

`ifdef GFB_RSP_ABORT_EN
  logic abort_s1;
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      abort_s1 <= 1'b0;
      abort_s2 <= 1'b0;
    end else begin
      abort_s1 <= bus.ABORT_REG_pclk;
      abort_s2 <= abort_s1;
    end
  end
`else
  wire unused_abort = bus.ABORT_REG_pclk;
  assign abort_s2 = 1'b0;
`endif

  assign addr_err = 32'(addr_q) >= DEPTH;

  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) state <= S_IDLE;
    else              state <= next_state;
  end

  // Next state plus per-cycle execute decisions (finish, error, memory write).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statements can infer a latch.
    next_state = state;
    finish     = 1'b0;
    fin_err    = 1'b0;
    load_rdata = 1'b0;
    clr_rdata  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    unique case (state)
      S_IDLE: if (start) next_state = S_EXEC;
      S_EXEC: begin
        unique case (cmd_q)
          CMD_NOP: finish = 1'b1;
          CMD_READ, CMD_WRITE, CMD_ERASE: begin
            if (addr_err) begin
              finish    = 1'b1;
              fin_err   = 1'b1;
              clr_rdata = (cmd_q == CMD_READ);
            end else if (cnt == CW'(BUSY_CYCLES)) begin
              finish     = 1'b1;
              load_rdata = (cmd_q == CMD_READ);
              mem_we     = (cmd_q != CMD_READ);
              mem_waddr  = addr_q[AW-1:0];
              mem_wdata  = (cmd_q == CMD_WRITE) ? wdata_q : 10'h3FF;
            end
          end
          CMD_ROW_WRITE: begin
            if (addr_err || abort_s2) begin
              finish  = 1'b1;
              fin_err = 1'b1;
            end else begin
              // Row base is aligned, so OR-ing in the offset equals adding it.
              mem_we    = 1'b1;
              mem_waddr = (addr_q[AW-1:0] & ~AW'(ROW_SIZE - 1)) | cnt[AW-1:0];
              mem_wdata = wdata_q;
              finish    = (cnt == CW'(ROW_SIZE - 1));
            end
          end
          CMD_MASS_ERASE: begin
            if (abort_s2) begin
              finish  = 1'b1;
              fin_err = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = cnt[AW-1:0];
              mem_wdata = 10'h3FF;
              finish    = (cnt == CW'(DEPTH - 1));
            end
          end
          default: begin
            finish  = 1'b1;
            fin_err = 1'b1;
          end
        endcase
        if (finish) next_state = S_DONE;
      end
      S_DONE: if (!req_s2) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Bundle capture, execute counter and registered response outputs.
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      cmd_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt            <= '0;
      bus.ack_sclk   <= 1'b0;
      bus.RDATA_sclk <= '0;
      bus.RESP_sclk  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        cmd_q   <= bus.CMD_REG_pclk;
        addr_q  <= bus.ADDR_REG_pclk;
        wdata_q <= bus.WDATA_REG_pclk;
        cnt     <= '0;
      end else if (state == S_EXEC) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        bus.ack_sclk  <= 1'b1;
        bus.RESP_sclk <= fin_err;
        if (load_rdata)     bus.RDATA_sclk <= mem[addr_q[AW-1:0]];
        else if (clr_rdata) bus.RDATA_sclk <= '0;
      end else if (state == S_DONE && !req_s2) begin
        bus.ack_sclk <= 1'b0;
      end
    end
  end

  // NOTE: the word array has no reset; its contents survive RESETn_sclk and
  // are undefined after power-up, which also lets it map onto RAM.
  always_ff @(posedge SCLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.busy_sclk = (state == S_EXEC);

endmodule

// File: tb/tb_cmd_responder_sclk.sv
// ---------------------------------------------------------------------------
// tb_cmd_responder_sclk
// Self-checking bench for cmd_responder_sclk: directed handshakes from the
// test plan followed by randomized commands, all checked against a word-level
// model of the array, the response and the ack timing.
// ---------------------------------------------------------------------------
module tb_cmd_responder_sclk;
  localparam int DEPTH       = 64;
  localparam int ROW_SIZE    = 8;
  localparam int BUSY_CYCLES = 2;
`ifdef GFB_RSP_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [9:0] mdl [DEPTH];
  logic [9:0] exp_rdata = '0;
  logic       exp_resp = 1'b0;

  cmd_responder_sclk_if bus();

  cmd_responder_sclk #(
    .DEPTH(DEPTH), .ROW_SIZE(ROW_SIZE), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .SCLK(clk),
    .RESETn_sclk(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whenever ack is high the response must match the model.
  always @(negedge clk) begin
    if (rst_n && bus.ack_sclk) begin
      check("cmp_rdata", 32'(bus.RDATA_sclk), 32'(exp_rdata));
      check("cmp_resp", 32'(bus.RESP_sclk), 32'(exp_resp));
      check("cmp_busy", 32'(bus.busy_sclk), 32'd0);
    end
  end

  // One full 4-phase transaction. abort_a >= 0 raises ABORT_REG_pclk on the
  // negedge following edge E(abort_a); E0 is the first edge seeing req high.
  task automatic do_op(input logic [2:0] cmd, input logic [9:0] addr,
                       input logic [9:0] wdata, input int abort_a, output int lat);
    int n, stop, exp_lat, t0, f0, fall, base;
    logic err, rs;
    logic [9:0] rd;
    err = (cmd > 3'd5) || (cmd != 3'd0 && cmd != 3'd5 && 32'(addr) >= DEPTH);
    rd  = exp_rdata;
    rs  = 1'b0;
    exp_lat = 3;
    if (err) begin
      rs = 1'b1;
      if (cmd == 3'd1) rd = '0;
    end else begin
      case (cmd)
        3'd1: begin exp_lat = 3 + BUSY_CYCLES; rd = mdl[addr]; end
        3'd2: begin exp_lat = 3 + BUSY_CYCLES; mdl[addr] = wdata; end
        3'd4: begin exp_lat = 3 + BUSY_CYCLES; mdl[addr] = 10'h3FF; end
        3'd3, 3'd5: begin
          n    = (cmd == 3'd3) ? ROW_SIZE : DEPTH;
          base = (cmd == 3'd3) ? (int'(addr) / ROW_SIZE) * ROW_SIZE : 0;
          // Abort is seen two edges after it is raised and kills that write.
          stop = (ABORT_EN && abort_a >= 0 && abort_a < n) ? abort_a : n;
          for (int i = 0; i < stop; i++) mdl[base + i] = (cmd == 3'd3) ? wdata : 10'h3FF;
          exp_lat = (stop < n) ? abort_a + 3 : n + 2;
          rs = (stop < n);
        end
        default: exp_lat = 3;
      endcase
    end

    @(negedge clk);
    exp_rdata = rd;
    exp_resp  = rs;
    bus.CMD_REG_pclk   = cmd;
    bus.ADDR_REG_pclk  = addr;
    bus.WDATA_REG_pclk = wdata;
    bus.req_pclk       = 1'b1;
    t0  = cyc + 1;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (abort_a >= 0 && cyc - t0 == abort_a) bus.ABORT_REG_pclk = 1'b1;
      if (cyc - t0 == 2) check("busy_e2", 32'(bus.busy_sclk), 32'd1);
      if (bus.ack_sclk) begin
        lat = cyc - t0;
        break;
      end
    end
    check("ack_rise_edge", 32'(lat), 32'(exp_lat));
    check("resp", 32'(bus.RESP_sclk), 32'(rs));
    check("rdata", 32'(bus.RDATA_sclk), 32'(rd));

    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.req_pclk       = 1'b0;
    bus.ABORT_REG_pclk = 1'b0;
    f0   = cyc + 1;
    fall = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.ack_sclk) begin
        fall = cyc - f0;
        break;
      end
    end
    check("ack_fall_edge", 32'(fall), 32'd2);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, t0, stuck;
    logic [2:0] c;
    logic [9:0] a;
    int ab;

    bus.req_pclk       = 1'b0;
    bus.CMD_REG_pclk   = '0;
    bus.ADDR_REG_pclk  = '0;
    bus.WDATA_REG_pclk = '0;
    bus.ABORT_REG_pclk = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack_sclk), 32'd0);
    check("rst_busy", 32'(bus.busy_sclk), 32'd0);
    check("rst_rdata", 32'(bus.RDATA_sclk), 32'd0);
    check("rst_resp", 32'(bus.RESP_sclk), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Bring the array to a known state.
    do_op(3'd5, 10'd0, 10'd0, -1, lat);
    check("mass_lat", 32'(lat), 32'd66);

    do_op(3'd2, 10'd5, 10'h155, -1, lat);
    check("write_lat", 32'(lat), 32'd5);
    do_op(3'd1, 10'd5, 10'd0, -1, lat);
    check("read5_lat", 32'(lat), 32'd5);
    check("read5_data", 32'(bus.RDATA_sclk), 32'h155);

    do_op(3'd3, 10'h00B, 10'h2AA, -1, lat);
    check("row_lat", 32'(lat), 32'd10);
    for (int i = 8; i < 16; i++) begin
      do_op(3'd1, 10'(i), 10'd0, -1, lat);
      check("row_word", 32'(bus.RDATA_sclk), 32'h2AA);
    end
    do_op(3'd1, 10'd7, 10'd0, -1, lat);
    check("row_below", 32'(bus.RDATA_sclk), 32'h3FF);
    do_op(3'd1, 10'd16, 10'd0, -1, lat);
    check("row_above", 32'(bus.RDATA_sclk), 32'h3FF);

    do_op(3'd6, 10'd3, 10'd0, -1, lat);
    check("illegal_lat", 32'(lat), 32'd3);
    check("illegal_resp", 32'(bus.RESP_sclk), 32'd1);
    do_op(3'd1, 10'd64, 10'd0, -1, lat);
    check("oob_lat", 32'(lat), 32'd3);
    check("oob_rdata", 32'(bus.RDATA_sclk), 32'd0);
    check("oob_resp", 32'(bus.RESP_sclk), 32'd1);

    // Mass erase aborted 10 cycles after capture (E2 + 10).
    do_op(3'd5, 10'd0, 10'd0, 12, lat);
    check("abort_lat", 32'(lat), ABORT_EN ? 32'd15 : 32'd66);
    check("abort_resp", 32'(bus.RESP_sclk), ABORT_EN ? 32'd1 : 32'd0);
    do_op(3'd1, 10'd11, 10'd0, -1, lat);
    check("abort_erased", 32'(bus.RDATA_sclk), 32'h3FF);
    do_op(3'd1, 10'd12, 10'd0, -1, lat);
    check("abort_kept", 32'(bus.RDATA_sclk), ABORT_EN ? 32'h2AA : 32'h3FF);

    // Reset in the middle of a ROW_WRITE to row 0x20: edges E3..E6 land words 0..3.
    @(negedge clk);
    bus.CMD_REG_pclk   = 3'd3;
    bus.ADDR_REG_pclk  = 10'h020;
    bus.WDATA_REG_pclk = 10'h0F0;
    bus.req_pclk       = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 20 && cyc - t0 < 6; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(bus.ack_sclk), 32'd0);
    check("midrst_busy", 32'(bus.busy_sclk), 32'd0);
    check("midrst_rdata", 32'(bus.RDATA_sclk), 32'd0);
    check("midrst_resp", 32'(bus.RESP_sclk), 32'd0);
    for (int i = 0; i < 4; i++) mdl[32 + i] = 10'h0F0;
    exp_rdata = '0;
    exp_resp  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stuck = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy_sclk || bus.ack_sclk) stuck = 1;
    end
    check("no_op_req_held", 32'(stuck), 32'd0);
    bus.req_pclk = 1'b0;
    repeat (5) @(negedge clk);
    do_op(3'd1, 10'h023, 10'd0, -1, lat);
    check("midrst_kept", 32'(bus.RDATA_sclk), 32'h0F0);
    do_op(3'd1, 10'h024, 10'd0, -1, lat);
    check("midrst_unwritten", 32'(bus.RDATA_sclk), 32'h3FF);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      c  = 3'($urandom_range(0, 7));
      if (c == 3'd5 && $urandom_range(0, 2) != 0) c = 3'd1;
      a  = ($urandom_range(0, 99) < 85) ? 10'($urandom_range(0, 63)) : 10'($urandom_range(64, 1023));
      ab = -1;
      if (c == 3'd3 && $urandom_range(0, 1) == 1) ab = $urandom_range(2, 10);
      if (c == 3'd5 && $urandom_range(0, 1) == 1) ab = $urandom_range(2, 70);
      if (c == 3'd2 && $urandom_range(0, 3) == 0) ab = $urandom_range(2, 4);
      do_op(c, a, 10'($urandom_range(0, 1023)), ab, lat);
    end

    // Sweep the whole array against the model.
    for (int i = 0; i < DEPTH; i++) do_op(3'd1, 10'(i), 10'd0, -1, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/cmd_responder_sclk.md
# cmd_responder_sclk

SCLK-domain responder for the GFB command handshake: it synchronizes the initiator's `req_pclk`, captures the quasi-static command bundle (`CMD_REG_pclk`, `ADDR_REG_pclk`, `WDATA_REG_pclk`, `ABORT_REG_pclk`) and executes it against a local word array. It then returns `RDATA_sclk` and `RESP_sclk` under a 4-phase `ack_sclk`. It is the far end of the PCLK-side command initiator and closes the response path, including read data, error status and abort.

## Interface
- `DEPTH`, 64, implemented words; addresses `>= DEPTH` are errors.
- `ROW_SIZE`, 8, words per row; must be a power of 2 that divides `DEPTH`.
- `BUSY_CYCLES`, 2, extra execute cycles for single-word ops; must be ≥ 0.

Ports:
- `SCLK`  in  1  sole clock.
- `RESETn_sclk`  in  1  reset, asynchronous, active-low.
- `req_pclk`  in  1  request from the PCLK domain (asynchronous).
- `CMD_REG_pclk`  in  3  command: 0 NOP, 1 READ, 2 WRITE, 3 ROW_WRITE, 4 ERASE, 5 MASS_ERASE, 6/7 illegal.
- `ADDR_REG_pclk`  in  10  word address.
- `WDATA_REG_pclk`  in  10  write data.
- `ABORT_REG_pclk`  in  1  abort level (asynchronous).
- `ack_sclk`  out  1  acknowledge; RDATA/RESP valid while high.
- `RDATA_sclk`  out  10  read data.
- `RESP_sclk`  out  1  1 = error or aborted.
- `busy_sclk`  out  1  high in the EXEC state.

## Operation
- **Synchronizers:** `req_pclk` passes through a 2-FF synchronizer (`req_s1`, `req_s2`) plus a delay stage `req_s3`; `start = req_s2 & ~req_s3`. `ABORT_REG_pclk` uses its own 2-FF synchronizer (`abort_s2`).
- **Bundle sampling:** the bundle is sampled directly only on the `start` cycle. The protocol guarantees it is stable from `req_pclk` rise until `ack_sclk` fall.
- **States:** IDLE, EXEC, DONE.
- **IDLE:** on `start`, capture the bundle and enter EXEC with `cnt = 0`. A `req_s2` level with no rising edge is ignored.
- **EXEC:** `cnt` increments each cycle.
  - NOP: finishes at `cnt == 0` with RESP=0, no memory change.
  - Illegal CMD, or ADDR ≥ DEPTH for READ/WRITE/ROW_WRITE/ERASE: finishes at `cnt == 0` with RESP=1, no memory change. RDATA is unchanged except on READ, where it becomes 0.
  - READ / WRITE / ERASE: finish at `cnt == BUSY_CYCLES`. READ sets `RDATA = mem[ADDR]`; WRITE sets `mem[ADDR] = WDATA`; ERASE sets `mem[ADDR] = 10'h3FF`.
  - ROW_WRITE: writes `mem[(ADDR & ~(ROW_SIZE-1)) + cnt] = WDATA`, one word per cycle for `cnt` 0..ROW_SIZE-1, finishing on the last write.
  - MASS_ERASE: writes `mem[cnt] = 10'h3FF` for `cnt` 0..DEPTH-1 and ignores ADDR.
- **Finish:** on the finish edge, `ack_sclk` goes to 1, RDATA/RESP are updated and the FSM enters DONE.
- **Abort:** if `abort_s2` is high during an EXEC cycle of ROW_WRITE or MASS_ERASE, that cycle's write is suppressed and the op finishes with RESP=1. Words already written remain. Single-word ops and NOP ignore abort.
- **DONE:** `ack_sclk`, RDATA and RESP are held. When `req_s2 == 0`, `ack_sclk` goes to 0 and the FSM returns to IDLE.
- **Reset:** reset asserted at any point forces all outputs to 0 and the FSM to IDLE, and clears the synchronizers and `cnt`. An op interrupted mid-way is not resumed. The memory array is not reset: its contents are retained across reset and are X after power-up.

## Timing
- Let E0 be the first SCLK edge that samples `req_pclk == 1`. Then `req_s2` is high at E1, capture happens at E2, and `busy_sclk` is high from E2.
- `ack_sclk` rises at:
  - NOP / illegal / address error: E3.
  - READ / WRITE / ERASE: E2 + BUSY_CYCLES + 1 (E5 at default).
  - ROW_WRITE: E2 + ROW_SIZE (E10 at default).
  - MASS_ERASE: E2 + DEPTH (E66 at default).
- `busy_sclk` falls at the same edge `ack_sclk` rises.
- If F0 is the first edge that samples `req_pclk == 0` during DONE, `ack_sclk` falls at F0 + 2.
- The earliest next capture is 3 edges after `req_pclk` re-rises.
- `req_pclk` rising during EXEC or DONE is a protocol violation and is not detected. If `req_pclk` falls during EXEC, the op still completes; `ack_sclk` pulses for 1 cycle and the FSM then returns to IDLE.

## Configuration
- `GFB_RSP_ABORT_EN`
  - Defined: the abort synchronizer and early termination exist as described above.
  - Undefined: `ABORT_REG_pclk` is unused, ROW_WRITE and MASS_ERASE always run to completion, and RESP is set only by illegal command or address error.

## Test plan
- WRITE addr 5 data 0x155, then READ addr 5: `ack_sclk` rises 5 edges after E0, RESP=0, RDATA=0x155; ack falls 2 edges after req falls.
- ROW_WRITE addr 0x0B data 0x2AA, then READ addr 8..15: all read 0x2AA; addr 7 and addr 16 are unchanged.
- MASS_ERASE with `ABORT_REG_pclk` raised 10 cycles after capture (`GFB_RSP_ABORT_EN` defined): RESP=1; low addresses read 0x3FF, addresses from the abort point onward keep their old data.
- CMD=6, and separately READ with addr 64: ack rises at E3, RESP=1, memory unchanged, RDATA=0 for the READ case.
- `RESETn_sclk` pulsed low mid-ROW_WRITE: `ack_sclk`/`busy_sclk`/RDATA/RESP go to 0 immediately; `req_pclk` still high after reset produces no new op until it toggles.
